// File: rtl/signal_decimator.sv
// signal_decimator: boxcar-average each block of 2^k valid samples, one strobe per block.
module signal_decimator #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_LOG_FACTOR = 10
) (
  input  logic                         SYS_aclk,
  input  logic                         SYS_aresetn,
  input  logic [3:0]                   log_factor,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid
);
  localparam int AW = DATA_WIDTH + MAX_LOG_FACTOR;
  localparam int CW = MAX_LOG_FACTOR + 1;
  logic signed [AW-1:0] acc, sum;
  logic [MAX_LOG_FACTOR-1:0] count;
  logic [3:0] k_active, k_req, k_eff;
  logic [CW-1:0] blk_len;
  logic last;
  // at a block boundary the freshly requested factor governs the accepted sample
  always_comb begin
    k_req   = (log_factor > 4'(MAX_LOG_FACTOR)) ? 4'(MAX_LOG_FACTOR) : log_factor;
    k_eff   = (count == '0) ? k_req : k_active;
    blk_len = CW'(1) << k_eff;
    last    = {1'b0, count} == blk_len - CW'(1);
    sum     = acc + AW'(in_data);
  end
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      acc       <= '0;
      count     <= '0;
      k_active  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        acc      <= '0;
        count    <= '0;
        k_active <= k_req;
      end else if (in_valid && last) begin
        out_data  <= DATA_WIDTH'(sum >>> k_eff);
        out_valid <= 1'b1;
        acc       <= '0;
        count     <= '0;
        k_active  <= k_req;
      end else if (in_valid) begin
        acc      <= sum;
        count    <= count + 1'b1;
        k_active <= k_eff;
      end else if (count == '0) begin
        k_active <= k_req;
      end
    end
  end
endmodule

// File: tb/tb_signal_decimator.sv
// tb_signal_decimator: directed stimulus with a block-average model feeding an expected-output queue.
module tb_signal_decimator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] log_factor = '0;
  logic clear = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_valid = 1'b0;
  logic signed [15:0] out_data;
  logic out_valid;
  int tests = 0;
  int fails = 0;
  int q[$];
  longint m_acc = 0;
  int m_cnt = 0;
  int m_k = 0;
  int last_out = 0;

  always #5 clk = ~clk;

  signal_decimator #(.DATA_WIDTH(16), .MAX_LOG_FACTOR(10)) dut (
    .SYS_aclk(clk), .SYS_aresetn(rst_n), .log_factor(log_factor), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input int d, input int lf, input logic c);
    logic exp_v;
    int exp_d;
    @(negedge clk);
    in_valid = v;
    in_data = d[15:0];
    log_factor = lf[3:0];
    clear = c;
    exp_v = 1'b0;
    if (c) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (v) begin
      if (m_cnt == 0) m_k = (lf > 10) ? 10 : lf;
      m_acc += d;
      m_cnt++;
      if (m_cnt == (1 << m_k)) begin
        q.push_back(int'(m_acc >>> m_k));
        exp_v = 1'b1;
        m_acc = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    if (exp_v) begin
      exp_d = q.pop_front();
      check("out_data", out_data, exp_d);
      last_out = exp_d;
    end else begin
      check("out_data_hold", out_data, last_out);
    end
  endtask

  task automatic run(input int n, input int d, input int lf);
    for (int i = 0; i < n; i++) step(1'b1, d, lf, 1'b0);
  endtask

  task automatic idle(input int n, input int lf);
    for (int i = 0; i < n; i++) step(1'b0, 0, lf, 1'b0);
  endtask

  initial begin
    #12;
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 2);
    run(12, 14, 2);
    check("avg_14", last_out, 14);
    run(16, -29, 3);
    check("avg_neg29", last_out, -29);
    for (int i = 1; i <= 4; i++) step(1'b1, i, 2, 1'b0);
    check("avg_1234", last_out, 2);
    for (int i = 1; i <= 4; i++) step(1'b1, -i, 2, 1'b0);
    check("avg_floor_neg", last_out, -3);
    run(1024, -32768, 10);
    check("full_neg", last_out, -32768);
    run(1024, 32767, 10);
    check("full_pos", last_out, 32767);
    step(1'b1, 7, 0, 1'b0);
    idle(1, 0);
    step(1'b1, 16, 0, 1'b0);
    step(1'b1, -5, 0, 1'b0);
    check("pass_last", last_out, -5);
    idle(1, 0);
    run(1023, 5, 15);
    check("clamp_no_strobe_yet", last_out, -5);
    run(1, 5, 15);
    check("clamp_strobe", last_out, 5);
    step(1'b1, 7, 2, 1'b0);
    step(1'b1, 16, 2, 1'b0);
    idle(5, 2);
    step(1'b1, 7, 2, 1'b0);
    step(1'b1, 16, 2, 1'b0);
    check("gap_avg", last_out, 11);
    step(1'b1, 1, 2, 1'b0);
    step(1'b1, 1, 1, 1'b0);
    step(1'b1, 1, 1, 1'b0);
    step(1'b1, 5, 1, 1'b0);
    check("lf_change_cur", last_out, 2);
    step(1'b1, 4, 1, 1'b0);
    step(1'b1, 6, 1, 1'b0);
    check("lf_change_next", last_out, 5);
    run(2, 3, 2);
    step(1'b1, 100, 2, 1'b1);
    check("clear_hold", out_data, 5);
    run(4, 8, 2);
    check("after_clear", last_out, 8);
    run(2, 9, 2);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 0);
    check("async_rst_data", out_data, 0);
    m_acc = 0;
    m_cnt = 0;
    last_out = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 9, 2);
    check("post_rst_no_strobe", out_data, 0);
    run(1, 9, 2);
    check("post_rst_avg", last_out, 9);
    idle(2, 2);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
